// File: rtl/sramlike_bus_arbiter.sv
// Shares one sram-like master port between instruction and data requesters.
// One transaction in flight; the grant is locked from request until data_ok.
module sramlike_bus_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        busy,
  output logic        protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic G_INST = 1'b0;
  localparam logic G_DATA = 1'b1;

  state_t      r_state;
  state_t      w_next;
  logic        r_grant;
  logic        r_lastGrant;
  logic        r_protoErr;
  logic        r_holdWr;
  logic [1:0]  r_holdSize;
  logic [31:0] r_holdAddr;
  logic [31:0] r_holdWdata;
  logic        w_nextGrant;
  logic        w_anyReq;
  logic        w_selWr;
  logic [1:0]  w_selSize;
  logic [31:0] w_selAddr;
  logic [31:0] w_selWdata;
  logic        w_addrOk;
  logic        w_dataOk;
  logic        w_stray;

  assign w_anyReq = inst_req | data_req;

  always_comb begin
    w_selWr    = r_grant ? data_wr    : inst_wr;
    w_selSize  = r_grant ? data_size  : inst_size;
    w_selAddr  = r_grant ? data_addr  : inst_addr;
    w_selWdata = r_grant ? data_wdata : inst_wdata;
  end

  // On a tie, round-robin hands the port to whoever did not have it last.
  always_comb begin
    w_nextGrant = r_grant;
    if (inst_req && data_req) begin
      w_nextGrant = (PRIO_MODE == 1) ? G_DATA : ~r_lastGrant;
    end else if (data_req) begin
      w_nextGrant = G_DATA;
    end else if (inst_req) begin
      w_nextGrant = G_INST;
    end
  end

  always_comb begin
    w_next   = r_state;
    m_req    = 1'b0;
    m_wr     = 1'b0;
    m_size   = 2'd0;
    m_addr   = 32'd0;
    m_wdata  = 32'd0;
    w_addrOk = 1'b0;
    w_dataOk = 1'b0;
    w_stray  = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE: begin
        w_stray = m_data_ok;
        if (w_anyReq) begin
          w_next = ADDR;
        end
      end
      ADDR: begin
        busy     = 1'b1;
        m_req    = 1'b1;
        m_wr     = w_selWr;
        m_size   = w_selSize;
        m_addr   = w_selAddr;
        m_wdata  = w_selWdata;
        w_addrOk = m_addr_ok;
        if (m_addr_ok) begin
          if (m_data_ok) begin
            w_dataOk = 1'b1;
            w_next   = IDLE;
          end else begin
            w_next = DATA;
          end
        end else begin
          w_stray = m_data_ok;
        end
      end
      DATA: begin
        busy    = 1'b1;
        m_wr    = r_holdWr;
        m_size  = r_holdSize;
        m_addr  = r_holdAddr;
        m_wdata = r_holdWdata;
        if (m_data_ok) begin
          w_dataOk = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_grant     <= G_INST;
      r_lastGrant <= G_INST;
      r_protoErr  <= 1'b0;
      r_holdWr    <= 1'b0;
      r_holdSize  <= 2'd0;
      r_holdAddr  <= 32'd0;
      r_holdWdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_anyReq) begin
        r_grant     <= w_nextGrant;
        r_lastGrant <= w_nextGrant;
      end
      // Snapshot the accepted payload so DATA can keep presenting it.
      if (r_state == ADDR && m_addr_ok) begin
        r_holdWr    <= w_selWr;
        r_holdSize  <= w_selSize;
        r_holdAddr  <= w_selAddr;
        r_holdWdata <= w_selWdata;
      end
      if (w_stray) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  assign inst_addr_ok = w_addrOk & (r_grant == G_INST);
  assign data_addr_ok = w_addrOk & (r_grant == G_DATA);
  assign inst_data_ok = w_dataOk & (r_grant == G_INST);
  assign data_data_ok = w_dataOk & (r_grant == G_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign protocol_err = r_protoErr;

endmodule
